// File: rtl/pdp_mem_arbiter_pkg.sv
// Shared types and widths for the PDP-8 memory-port arbiter.
package pdp_mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;
  localparam int LAT_W      = 3;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_IFU,
    SRC_EXRD,
    SRC_EXWR
  } arb_src_e;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                   input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? lim : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/pdp_mem_arbiter_if.sv
// Requester ports (IFU read, execute read/write) and the single memory port.
interface pdp_mem_arbiter_if;
  import pdp_mem_arbiter_pkg::*;

  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  ifu_rd_ack;
  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  exec_rd_ack;
  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic                  exec_wr_ack;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  arb_busy;

  modport slave (
    input  ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
           exec_wr_req, exec_wr_addr, exec_wr_data, mem_rdata,
    output ifu_rd_data, ifu_rd_ack, exec_rd_data, exec_rd_ack, exec_wr_ack,
           mem_req, mem_we, mem_addr, mem_wdata, arb_busy
  );

  modport master (
    output ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
           exec_wr_req, exec_wr_addr, exec_wr_data, mem_rdata,
    input  ifu_rd_data, ifu_rd_ack, exec_rd_data, exec_rd_ack, exec_wr_ack,
           mem_req, mem_we, mem_addr, mem_wdata, arb_busy
  );

endinterface

// File: rtl/pdp_mem_arbiter_prio.sv
// Combinational winner select: exec_wr > exec_rd > ifu_rd, unless the IFU is starved.
module pdp_arb_prio
  import pdp_mem_arbiter_pkg::*;
(
  input  logic     i_ifu_req,
  input  logic     i_exrd_req,
  input  logic     i_exwr_req,
  input  logic     i_starve_ovr,
  output arb_src_e o_src
);

  always_comb begin
    o_src = SRC_NONE;
    if (i_starve_ovr && i_ifu_req) begin
      o_src = SRC_IFU;
    end else if (i_exwr_req) begin
      o_src = SRC_EXWR;
    end else if (i_exrd_req) begin
      o_src = SRC_EXRD;
    end else if (i_ifu_req) begin
      o_src = SRC_IFU;
    end
  end

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Shares one PDP-8 memory port between instruction fetch and the execute unit's
// read and write ports: one access at a time, fixed latency, one-cycle ack.
module pdp_mem_arbiter
  import pdp_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  pdp_mem_arbiter_if.slave    bus,
  output arb_state_e          o_dbg_state,
  output arb_src_e            o_dbg_src,
  output logic [STARVE_W-1:0] o_dbg_starve_cnt
);

  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  // Handshake: a requester holds req/addr/wdata until it samples its ack and drops
  // req on that same edge; requests are only sampled in ARB_IDLE, so a req still
  // high in the cycle after its ack is simply a new request.

  arb_state_e            r_state;
  arb_state_e            w_next_state;
  arb_src_e              r_src;
  arb_src_e              w_win;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_ifu_rd_data;
  logic [DATA_WIDTH-1:0] r_exec_rd_data;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic                  w_starve_ovr;
  logic                  w_grant;
  logic                  w_mem_req;
  logic                  w_mem_we;
  logic                  w_ifu_ack;
  logic                  w_exrd_ack;
  logic                  w_exwr_ack;
  logic                  w_busy;

  assign w_starve_ovr = (r_starve_cnt == STARVE_MAX);

  pdp_arb_prio u_prio (
    .i_ifu_req   (bus.ifu_rd_req),
    .i_exrd_req  (bus.exec_rd_req),
    .i_exwr_req  (bus.exec_wr_req),
    .i_starve_ovr(w_starve_ovr),
    .o_src       (w_win)
  );

  assign w_grant = (r_state == ARB_IDLE) && (w_win != SRC_NONE);

  always_comb begin
    w_win_addr = bus.ifu_rd_addr;
    case (w_win)
      SRC_EXRD: w_win_addr = bus.exec_rd_addr;
      SRC_EXWR: w_win_addr = bus.exec_wr_addr;
      default:  w_win_addr = bus.ifu_rd_addr;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_ifu_ack    = 1'b0;
    w_exrd_ack   = 1'b0;
    w_exwr_ack   = 1'b0;
    w_busy       = (r_state != ARB_IDLE);
    case (r_state)
      ARB_IDLE: begin
        if (w_grant) w_next_state = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        w_mem_req    = 1'b1;
        w_mem_we     = (r_src == SRC_EXWR);
        w_next_state = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (r_lat_cnt == LAT_W'(1)) w_next_state = ARB_RESP;
      end
      ARB_RESP: begin
        w_ifu_ack    = (r_src == SRC_IFU);
        w_exrd_ack   = (r_src == SRC_EXRD);
        w_exwr_ack   = (r_src == SRC_EXWR);
        w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src          <= SRC_NONE;
      r_lat_cnt      <= '0;
      r_starve_cnt   <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_ifu_rd_data  <= '0;
      r_exec_rd_data <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_src      <= w_win;
            r_mem_addr <= w_win_addr;
            if (w_win == SRC_EXWR) r_mem_wdata <= bus.exec_wr_data;
          end
          // Starvation only counts arbitrations the IFU actually took part in.
          if (bus.ifu_rd_req) begin
            r_starve_cnt <= (w_win == SRC_IFU) ? '0 : sat_inc(r_starve_cnt, STARVE_MAX);
          end
        end
        ARB_ISSUE: r_lat_cnt <= LAT_LOAD;
        ARB_WAIT: begin
          r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          // Capture straight into the per-port register so data is valid with the ack.
          if (r_lat_cnt == LAT_W'(1)) begin
            if (r_src == SRC_IFU)  r_ifu_rd_data  <= bus.mem_rdata;
            if (r_src == SRC_EXRD) r_exec_rd_data <= bus.mem_rdata;
          end
        end
        ARB_RESP: r_src <= SRC_NONE;
        default:  r_src <= SRC_NONE;
      endcase
    end
  end

  assign bus.mem_req      = w_mem_req;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.ifu_rd_ack   = w_ifu_ack;
  assign bus.exec_rd_ack  = w_exrd_ack;
  assign bus.exec_wr_ack  = w_exwr_ack;
  assign bus.ifu_rd_data  = r_ifu_rd_data;
  assign bus.exec_rd_data = r_exec_rd_data;
  assign bus.arb_busy     = w_busy;

  assign o_dbg_state      = r_state;
  assign o_dbg_src        = r_src;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Bench for pdp_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), a memory
// model per instance, and a priority/starvation reference model.
module tb_pdp_mem_arbiter;
  import pdp_mem_arbiter_pkg::*;

  localparam int STARVE = 4;
  localparam int LAT1   = 1;
  localparam int LAT3   = 3;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pdp_mem_arbiter_if bus1 ();
  pdp_mem_arbiter_if bus3 ();

  arb_state_e          dbg_state1, dbg_state3;
  arb_src_e            dbg_src1, dbg_src3;
  logic [STARVE_W-1:0] dbg_starve1, dbg_starve3;

  pdp_mem_arbiter #(.MEM_LAT(LAT1), .STARVE_LIMIT(STARVE)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave),
    .o_dbg_state(dbg_state1), .o_dbg_src(dbg_src1), .o_dbg_starve_cnt(dbg_starve1)
  );

  pdp_mem_arbiter #(.MEM_LAT(LAT3), .STARVE_LIMIT(STARVE)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.slave),
    .o_dbg_state(dbg_state3), .o_dbg_src(dbg_src3), .o_dbg_starve_cnt(dbg_starve3)
  );

  // ---------------- memory models ----------------
  // mem* is the physical memory written only by DUT strobes; ref* is what the
  // bench believes memory holds, updated when a write is acknowledged.
  word_t mem1 [DEPTH];
  word_t ref1 [DEPTH];
  word_t mem3 [DEPTH];
  word_t ref3 [DEPTH];
  int    rd_cnt1 = 0;
  int    rd_cnt3 = 0;
  addr_t raddr1 = '0;
  addr_t raddr3 = '0;

  // Read data is only correct in the single cycle MEM_LAT after mem_req.
  always @(negedge clk) begin
    bus1.mem_rdata = ~mem1[raddr1];
    if (rd_cnt1 > 0) begin
      rd_cnt1 = rd_cnt1 - 1;
      if (rd_cnt1 == 0) bus1.mem_rdata = mem1[raddr1];
    end
    if (bus1.mem_req) begin
      if (bus1.mem_we) mem1[bus1.mem_addr] = bus1.mem_wdata;
      else begin
        rd_cnt1 = LAT1;
        raddr1  = bus1.mem_addr;
      end
    end
  end

  always @(negedge clk) begin
    bus3.mem_rdata = ~mem3[raddr3];
    if (rd_cnt3 > 0) begin
      rd_cnt3 = rd_cnt3 - 1;
      if (rd_cnt3 == 0) bus3.mem_rdata = mem3[raddr3];
    end
    if (bus3.mem_req) begin
      if (bus3.mem_we) mem3[bus3.mem_addr] = bus3.mem_wdata;
      else begin
        rd_cnt3 = LAT3;
        raddr3  = bus3.mem_addr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_reqs();
    bus1.ifu_rd_req = 1'b0; bus1.exec_rd_req = 1'b0; bus1.exec_wr_req = 1'b0;
    bus1.ifu_rd_addr = '0; bus1.exec_rd_addr = '0; bus1.exec_wr_addr = '0; bus1.exec_wr_data = '0;
    bus3.ifu_rd_req = 1'b0; bus3.exec_rd_req = 1'b0; bus3.exec_wr_req = 1'b0;
    bus3.ifu_rd_addr = '0; bus3.exec_rd_addr = '0; bus3.exec_wr_addr = '0; bus3.exec_wr_data = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus1.mem_req, bus1.mem_we, bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack, bus1.arb_busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl1: got %b want 000000", {bus1.mem_req, bus1.mem_we, bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack, bus1.arb_busy});
    end
    n_checks++;
    if ({bus1.mem_addr, bus1.mem_wdata, bus1.ifu_rd_data, bus1.exec_rd_data} !== '0) begin
      n_fail++; $display("FAIL reset_data1: got %h %h %h %h want all 0", bus1.mem_addr, bus1.mem_wdata, bus1.ifu_rd_data, bus1.exec_rd_data);
    end
    n_checks++;
    if (dbg_state1 !== ARB_IDLE || dbg_src1 !== SRC_NONE || dbg_starve1 !== '0) begin
      n_fail++; $display("FAIL reset_fsm1: state %0d src %0d starve %0d want 0 0 0", dbg_state1, dbg_src1, dbg_starve1);
    end
    n_checks++;
    if ({bus3.mem_req, bus3.arb_busy, bus3.ifu_rd_ack, bus3.exec_rd_ack, bus3.exec_wr_ack} !== 5'b0 || dbg_state3 !== ARB_IDLE) begin
      n_fail++; $display("FAIL reset_dut3: ctrl %b state %0d want 0 / IDLE", {bus3.mem_req, bus3.arb_busy, bus3.ifu_rd_ack, bus3.exec_rd_ack, bus3.exec_wr_ack}, dbg_state3);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_exec_read();
    @(posedge clk); #1;
    mem1[12'o0200] = 12'o7402; ref1[12'o0200] = 12'o7402;
    bus1.exec_rd_addr = 12'o0200; bus1.exec_rd_req = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          n_checks++;
          if ({bus1.mem_req, bus1.mem_we} !== 2'b10 || bus1.mem_addr !== 12'o0200) begin
            n_fail++; $display("FAIL t1_issue: req/we %b addr %o want 10 / 0200", {bus1.mem_req, bus1.mem_we}, bus1.mem_addr);
          end
        end
        3: begin
          n_checks++;
          if ({bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack} !== 3'b010 || bus1.exec_rd_data !== 12'o7402) begin
            n_fail++; $display("FAIL t1_ack: acks %b data %o want 010 / 7402", {bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack}, bus1.exec_rd_data);
          end
          @(posedge clk); #1; bus1.exec_rd_req = 1'b0;
        end
        default: begin
          n_checks++;
          if (bus1.exec_rd_ack !== 1'b0 || bus1.mem_req !== (k == 1)) begin
            n_fail++; $display("FAIL t1_quiet_k%0d: ack %b mem_req %b want 0 0", k, bus1.exec_rd_ack, bus1.mem_req);
          end
        end
      endcase
    end
  endtask

  task automatic test_write_first();
    word_t wd;
    addr_t ai;
    @(posedge clk); #1;
    wd = word_t'($urandom);
    ai = addr_t'(12'o0400 + $urandom_range(0, 63));
    bus1.exec_wr_addr = 12'o0055; bus1.exec_wr_data = wd; bus1.exec_wr_req = 1'b1;
    bus1.ifu_rd_addr = ai; bus1.ifu_rd_req = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if ({bus1.mem_req, bus1.mem_we} !== 2'b11 || bus1.mem_addr !== 12'o0055 || bus1.mem_wdata !== wd || dbg_starve1 !== 4'd1) begin
          n_fail++; $display("FAIL t2_write_issue: req/we %b addr %o wdata %o starve %0d want 11 0055 %o 1", {bus1.mem_req, bus1.mem_we}, bus1.mem_addr, bus1.mem_wdata, dbg_starve1, wd);
        end
      end else if (k == 3) begin
        n_checks++;
        if ({bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack} !== 3'b001) begin
          n_fail++; $display("FAIL t2_wr_ack: acks %b want 001", {bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack});
        end
        ref1[12'o0055] = wd;
        @(posedge clk); #1; bus1.exec_wr_req = 1'b0;
      end else if (k == 5) begin
        n_checks++;
        if ({bus1.mem_req, bus1.mem_we} !== 2'b10 || bus1.mem_addr !== ai || dbg_starve1 !== 4'd0) begin
          n_fail++; $display("FAIL t2_ifu_issue: req/we %b addr %o starve %0d want 10 %o 0", {bus1.mem_req, bus1.mem_we}, bus1.mem_addr, dbg_starve1, ai);
        end
      end else if (k == 7) begin
        n_checks++;
        if ({bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack} !== 3'b100 || bus1.ifu_rd_data !== ref1[ai]) begin
          n_fail++; $display("FAIL t2_ifu_ack: acks %b data %o want 100 %o", {bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack}, bus1.ifu_rd_data, ref1[ai]);
        end
        @(posedge clk); #1; bus1.ifu_rd_req = 1'b0;
      end else if (k == 8) begin
        n_checks++;
        if (mem1[12'o0055] !== wd) begin
          n_fail++; $display("FAIL t2_mem_written: got %o want %o", mem1[12'o0055], wd);
        end
      end
    end
  endtask

  task automatic test_starvation();
    addr_t ai, ar;
    logic [2:0] got, want;
    int exp_starve;
    @(posedge clk); #1;
    ai = addr_t'(12'o0600 + $urandom_range(0, 63));
    ar = addr_t'(12'o0700 + $urandom_range(0, 63));
    bus1.ifu_rd_addr = ai; bus1.ifu_rd_req = 1'b1;
    bus1.exec_rd_addr = ar; bus1.exec_rd_req = 1'b1;
    for (int r = 0; r < 6; r++) begin
      want = (r == 4) ? 3'b100 : 3'b010;
      exp_starve = (r < 4) ? r + 1 : 0;
      got = 3'b000;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        got = {bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack};
        if (got != 3'b000) break;
      end
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL t3_winner_r%0d: acks %b want %b", r, got, want);
      end
      n_checks++;
      if (dbg_starve1 !== STARVE_W'(exp_starve)) begin
        n_fail++; $display("FAIL t3_starve_r%0d: got %0d want %0d", r, dbg_starve1, exp_starve);
      end
      n_checks++;
      if ((want == 3'b100) ? (bus1.ifu_rd_data !== ref1[ai]) : (bus1.exec_rd_data !== ref1[ar])) begin
        n_fail++; $display("FAIL t3_data_r%0d: ifu %o exec %o want ifu %o exec %o", r, bus1.ifu_rd_data, bus1.exec_rd_data, ref1[ai], ref1[ar]);
      end
      @(posedge clk); #1;
      if (r == 4) bus1.ifu_rd_req = 1'b0;
      if (r == 5) bus1.exec_rd_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int first_req, second_req, nreq, nack;
    word_t want_d;
    first_req = -1; second_req = -1; nreq = 0; nack = 0;
    @(posedge clk); #1;
    mem1[12'o7777] = 12'o1111; ref1[12'o7777] = 12'o1111;
    mem1[12'o0000] = 12'o2222; ref1[12'o0000] = 12'o2222;
    bus1.exec_rd_addr = 12'o7777; bus1.exec_rd_req = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus1.mem_req) begin
        nreq++;
        if (nreq == 1) first_req = k;
        else if (nreq == 2) second_req = k;
      end
      if (bus1.exec_rd_ack) begin
        nack++;
        want_d = (nack == 1) ? 12'o1111 : 12'o2222;
        n_checks++;
        if (bus1.exec_rd_data !== want_d) begin
          n_fail++; $display("FAIL t4_data_%0d: got %o want %o", nack, bus1.exec_rd_data, want_d);
        end
        @(posedge clk); #1;
        if (nack == 1) bus1.exec_rd_addr = 12'o0000;
        else bus1.exec_rd_req = 1'b0;
      end
    end
    n_checks++;
    if (second_req - first_req !== LAT1 + 3) begin
      n_fail++; $display("FAIL t4_spacing: got %0d want %0d", second_req - first_req, LAT1 + 3);
    end
    n_checks++;
    if (nreq !== 2 || nack !== 2) begin
      n_fail++; $display("FAIL t4_counts: mem_req %0d acks %0d want 2 2", nreq, nack);
    end
  endtask

  task automatic test_reset_abort();
    addr_t ai, ar;
    logic [2:0] got, want;
    bit reached;
    @(posedge clk); #1;
    ai = addr_t'($urandom_range(0, DEPTH - 1));
    ar = addr_t'($urandom_range(0, DEPTH - 1));
    bus1.ifu_rd_addr = ai; bus1.ifu_rd_req = 1'b1;
    bus1.exec_rd_addr = ar; bus1.exec_rd_req = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dbg_state1 == ARB_WAIT) begin reached = 1'b1; break; end
    end
    n_checks++;
    if (reached !== 1'b1) begin
      n_fail++; $display("FAIL t5_reach_wait: got state %0d want %0d", dbg_state1, ARB_WAIT);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack, bus1.mem_req, bus1.arb_busy} !== 5'b0 || dbg_state1 !== ARB_IDLE || dbg_starve1 !== '0) begin
      n_fail++; $display("FAIL t5_abort: ctrl %b state %0d starve %0d want 0 IDLE 0", {bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack, bus1.mem_req, bus1.arb_busy}, dbg_state1, dbg_starve1);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.mem_req, bus1.arb_busy} !== 4'b0) begin
      n_fail++; $display("FAIL t5_held: ctrl %b want 0000", {bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.mem_req, bus1.arb_busy});
    end
    reset_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      want = (r == 0) ? 3'b010 : 3'b100;
      got = 3'b000;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        got = {bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack};
        if (got != 3'b000) break;
      end
      n_checks++;
      if (got !== want || ((r == 0) ? (bus1.exec_rd_data !== ref1[ar]) : (bus1.ifu_rd_data !== ref1[ai]))) begin
        n_fail++; $display("FAIL t5_rearb_r%0d: acks %b exec %o ifu %o want %b exec %o ifu %o", r, got, bus1.exec_rd_data, bus1.ifu_rd_data, want, ref1[ar], ref1[ai]);
      end
      @(posedge clk); #1;
      if (r == 0) bus1.exec_rd_req = 1'b0;
      else bus1.ifu_rd_req = 1'b0;
    end
  endtask

  task automatic test_latency3();
    addr_t ar;
    word_t exec_hold, ifu_hold;
    logic [2:0] acks;
    @(posedge clk); #1;
    ar = addr_t'(12'o0100 + $urandom_range(0, 63));
    ifu_hold = '0;
    // Phase 0: execute read, 1: write 1234 to 0050, 2: IFU read of 0050.
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 0) begin bus3.exec_rd_addr = ar; bus3.exec_rd_req = 1'b1; end
      if (ph == 1) begin bus3.exec_wr_addr = 12'o0050; bus3.exec_wr_data = 12'o1234; bus3.exec_wr_req = 1'b1; end
      if (ph == 2) begin bus3.ifu_rd_addr = 12'o0050; bus3.ifu_rd_req = 1'b1; end
      for (int k = 0; k <= LAT3 + 2; k++) begin
        @(negedge clk);
        acks = {bus3.ifu_rd_ack, bus3.exec_rd_ack, bus3.exec_wr_ack};
        if (k == 1) begin
          n_checks++;
          if (bus3.mem_req !== 1'b1 || bus3.mem_we !== (ph == 1) || bus3.mem_addr !== ((ph == 0) ? ar : 12'o0050)) begin
            n_fail++; $display("FAIL t6_issue_ph%0d: req %b we %b addr %o", ph, bus3.mem_req, bus3.mem_we, bus3.mem_addr);
          end
        end else if (k < LAT3 + 2) begin
          n_checks++;
          if (acks !== 3'b000 || bus3.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL t6_early_ph%0d_k%0d: acks %b mem_req %b want 000 0", ph, k, acks, bus3.mem_req);
          end
        end else begin
          if (ph == 0) exec_hold = ref3[ar];
          n_checks++;
          if (acks !== ((ph == 0) ? 3'b010 : (ph == 1) ? 3'b001 : 3'b100)) begin
            n_fail++; $display("FAIL t6_ack_ph%0d: acks %b", ph, acks);
          end
          if (ph == 1) ref3[12'o0050] = 12'o1234;
          if (ph == 2) ifu_hold = ref3[12'o0050];
          n_checks++;
          if (bus3.exec_rd_data !== exec_hold || bus3.ifu_rd_data !== ifu_hold) begin
            n_fail++; $display("FAIL t6_data_ph%0d: exec %o ifu %o want exec %o ifu %o", ph, bus3.exec_rd_data, bus3.ifu_rd_data, exec_hold, ifu_hold);
          end
          @(posedge clk); #1;
          bus3.exec_rd_req = 1'b0; bus3.exec_wr_req = 1'b0; bus3.ifu_rd_req = 1'b0;
        end
      end
    end
  endtask

  task automatic test_random();
    word_t exp_q[$];
    word_t got_d, exp_d;
    int starve_m;
    bit pi, pr, pw;
    addr_t ai, ar, aw;
    word_t dw;
    arb_src_e win;
    logic [2:0] want, got;
    int lat;
    starve_m = 0; pi = 0; pr = 0; pw = 0;
    ai = '0; ar = '0; aw = '0; dw = '0;
    @(posedge clk); #1;
    for (int r = 0; r < 40; r++) begin
      if (!pw && $urandom_range(0, 2) == 0) begin
        pw = 1; aw = addr_t'($urandom_range(0, 15)); dw = word_t'($urandom);
        bus1.exec_wr_addr = aw; bus1.exec_wr_data = dw; bus1.exec_wr_req = 1'b1;
      end
      if (!pr && $urandom_range(0, 1) == 0) begin
        pr = 1; ar = addr_t'($urandom_range(0, 15));
        bus1.exec_rd_addr = ar; bus1.exec_rd_req = 1'b1;
      end
      if (!pi && ($urandom_range(0, 1) == 0 || (!pr && !pw))) begin
        pi = 1; ai = addr_t'($urandom_range(0, 15));
        bus1.ifu_rd_addr = ai; bus1.ifu_rd_req = 1'b1;
      end
      if (pi && starve_m == STARVE) win = SRC_IFU;
      else if (pw) win = SRC_EXWR;
      else if (pr) win = SRC_EXRD;
      else win = SRC_IFU;
      if (win == SRC_IFU) starve_m = 0;
      else if (pi && starve_m < STARVE) starve_m++;
      want = (win == SRC_IFU) ? 3'b100 : (win == SRC_EXRD) ? 3'b010 : 3'b001;
      if (win == SRC_IFU) exp_q.push_back(ref1[ai]);
      else if (win == SRC_EXRD) exp_q.push_back(ref1[ar]);
      got = 3'b000; lat = -1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        got = {bus1.ifu_rd_ack, bus1.exec_rd_ack, bus1.exec_wr_ack};
        if (got != 3'b000) begin lat = k; break; end
      end
      n_checks++;
      if (got !== want || lat !== LAT1 + 2) begin
        n_fail++; $display("FAIL rand_grant_r%0d: acks %b lat %0d want %b lat %0d", r, got, lat, want, LAT1 + 2);
      end
      n_checks++;
      if (dbg_starve1 !== STARVE_W'(starve_m)) begin
        n_fail++; $display("FAIL rand_starve_r%0d: got %0d want %0d", r, dbg_starve1, starve_m);
      end
      if (win != SRC_EXWR) begin
        exp_d = exp_q.pop_front();
        got_d = (win == SRC_IFU) ? bus1.ifu_rd_data : bus1.exec_rd_data;
        n_checks++;
        if (got_d !== exp_d) begin
          n_fail++; $display("FAIL rand_data_r%0d: got %o want %o", r, got_d, exp_d);
        end
      end else begin
        ref1[aw] = dw;
      end
      @(posedge clk); #1;
      case (win)
        SRC_IFU:  begin pi = 0; bus1.ifu_rd_req = 1'b0; end
        SRC_EXRD: begin pr = 0; bus1.exec_rd_req = 1'b0; end
        default:  begin pw = 0; bus1.exec_wr_req = 1'b0; end
      endcase
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    clear_reqs();
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = word_t'($urandom); ref1[i] = mem1[i];
      mem3[i] = word_t'($urandom); ref3[i] = mem3[i];
    end
    test_reset();
    test_exec_read();
    test_write_first();
    test_starvation();
    test_back_to_back();
    test_reset_abort();
    test_latency3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
